// File: rtl/button_scan_ctrl.sv
// Debounce scheduler: one shared counter visits NUM_BTN synchronized buttons round-robin.
// Optional event stream (valid/ready, stalls COMMIT on backpressure) under `BTN_SCAN_EVT_EN.

module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module button_scan_ctrl #(
  parameter int NUM_BTN = 4,
  parameter int CNT_W   = 11,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] button_in,
  output logic [NUM_BTN-1:0] db_out,
  output logic [IDX_W-1:0]   scan_idx,
  output logic               busy
`ifdef BTN_SCAN_EVT_EN
  ,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [IDX_W-1:0]   evt_idx,
  output logic               evt_level
`endif
);

  typedef enum logic [1:0] {SCAN, COUNT, COMMIT} state_t;

  state_t             state, state_nxt;
  logic [NUM_BTN-1:0] sync;
  logic [IDX_W-1:0]   idx, idx_nxt, idx_inc;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic               cand, cand_nxt;
  logic               commit;
  logic               stall;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_sync
      btn_sync u_sync (.clk(clk), .reset(reset), .d(button_in[gi]), .q(sync[gi]));
    end
  endgenerate

  assign idx_inc = (idx == IDX_W'(NUM_BTN-1)) ? '0 : idx + IDX_W'(1);
  assign cnt_inc = cnt + CNT_W'(1);

`ifdef BTN_SCAN_EVT_EN
  // A pending event that is not being taken blocks the commit entirely.
  assign stall = evt_valid && !evt_ready;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    commit    = 1'b0;
    case (state)
      SCAN: begin
        if (sync[idx] != db_out[idx]) begin
          cand_nxt  = sync[idx];
          cnt_nxt   = '0;
          state_nxt = COUNT;
        end else begin
          idx_nxt = idx_inc;
        end
      end
      COUNT: begin
        // Bounce check takes priority, including on the final count cycle.
        if (sync[idx] != cand) begin
          cnt_nxt   = '0;
          idx_nxt   = idx_inc;
          state_nxt = SCAN;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc[CNT_W-1]) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        if (!stall) begin
          commit    = 1'b1;
          idx_nxt   = idx_inc;
          state_nxt = SCAN;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= SCAN;
      idx    <= '0;
      cnt    <= '0;
      cand   <= 1'b0;
      db_out <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
      if (commit) db_out[idx] <= cand;
    end
  end

`ifdef BTN_SCAN_EVT_EN
  // Load wins over the transfer-clear so back-to-back events need no gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_level <= 1'b0;
    end else if (commit) begin
      evt_valid <= 1'b1;
      evt_idx   <= idx;
      evt_level <= cand;
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end
`endif

  assign scan_idx = idx;
  assign busy     = (state != SCAN);

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Randomized bench for button_scan_ctrl against a per-cycle behavioural model of the scan rules.
// Event stream checks are included when BTN_SCAN_EVT_EN is defined.

module tb_button_scan_ctrl;
  localparam int NUM_BTN = 4;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 2;
  localparam int HALF    = 1 << (CNT_W-1);

  logic               clk;
  logic               reset;
  logic [NUM_BTN-1:0] button_in;
  logic [NUM_BTN-1:0] db_out;
  logic [IDX_W-1:0]   scan_idx;
  logic               busy;
  logic               evt_ready;
`ifdef BTN_SCAN_EVT_EN
  logic               evt_valid;
  logic [IDX_W-1:0]   evt_idx;
  logic               evt_level;
`endif

  int n_cmp = 0;
  int n_err = 0;

  button_scan_ctrl #(.NUM_BTN(NUM_BTN), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .button_in (button_in),
    .db_out    (db_out),
    .scan_idx  (scan_idx),
    .busy      (busy)
`ifdef BTN_SCAN_EVT_EN
    ,
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_idx   (evt_idx),
    .evt_level (evt_level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 = idle scanning, 1 = counting a candidate, 2 = committing.
  bit [NUM_BTN-1:0] m_s1, m_s2, m_db;
  int               m_idx, m_mode, m_run;
  bit               m_cand;
  bit               m_ev_v;
  int               m_ev_idx;
  bit               m_ev_lvl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_init();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    m_idx = 0; m_mode = 0; m_run = 0; m_cand = 0;
    m_ev_v = 0; m_ev_idx = 0; m_ev_lvl = 0;
  endtask

  task automatic model_step();
    bit s, done, hold;
    int ci;
    if (reset) begin
      model_init();
      return;
    end
    s    = m_s2[m_idx];
    ci   = m_idx;
    done = 0;
    hold = 0;
    case (m_mode)
      0: if (s != m_db[m_idx]) begin
           m_cand = s; m_run = 0; m_mode = 1;
         end else m_idx = (m_idx + 1) % NUM_BTN;
      1: if (s != m_cand) begin
           m_run = 0; m_idx = (m_idx + 1) % NUM_BTN; m_mode = 0;
         end else begin
           m_run++;
           if (m_run == HALF) m_mode = 2;
         end
      default: begin
`ifdef BTN_SCAN_EVT_EN
        hold = m_ev_v && !evt_ready;
`endif
        if (!hold) begin
          done = 1;
          m_db[m_idx] = m_cand;
          m_idx = (m_idx + 1) % NUM_BTN;
          m_mode = 0;
        end
      end
    endcase
    if (done) begin
      m_ev_v = 1; m_ev_idx = ci; m_ev_lvl = m_cand;
    end else if (m_ev_v && evt_ready) m_ev_v = 0;
    m_s2 = m_s1;
    m_s1 = button_in;
  endtask

  task automatic check_all();
    chk("db_out", db_out, m_db);
    chk("scan_idx", scan_idx, m_idx);
    chk("busy", busy, m_mode != 0);
`ifdef BTN_SCAN_EVT_EN
    chk("evt_valid", evt_valid, m_ev_v);
    if (m_ev_v) begin
      chk("evt_idx", evt_idx, m_ev_idx);
      chk("evt_level", evt_level, m_ev_lvl);
    end
`endif
  endtask

  // Inputs are only ever changed at the falling edge, after tick returns.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset     = 1'b1;
    button_in = '0;
    evt_ready = 1'b1;
    model_init();
    repeat (2) @(negedge clk);
    chk("rst_db", db_out, 0);
    chk("rst_idx", scan_idx, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // Clean press: drive when the scanner will be at button 0 as sync arrives.
    for (int k = 0; k < 8 && m_idx != 2; k++) tick();
    button_in[0] = 1'b1;
    repeat (11) tick();
    chk("press_early", db_out[0], 0);
    tick();
    chk("press_lat", db_out[0], 1);
    repeat (4) tick();

    // Asynchronous reset in the middle of counting button 2.
    button_in[2] = 1'b1;
    for (int k = 0; k < 40 && !(busy && scan_idx == 2); k++) tick();
    chk("rst_wait", busy && scan_idx == 2, 1);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_db", db_out, 0);
    chk("arst_idx", scan_idx, 0);
    chk("arst_busy", busy, 0);
`ifdef BTN_SCAN_EVT_EN
    chk("arst_evt", evt_valid, 0);
`endif
    model_init();
    button_in = '0;
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Bounce on button 1, then settle high.
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) button_in[1] = ~button_in[1];
      tick();
    end
    button_in[1] = 1'b1;
    repeat (30) tick();
    chk("bounce_db", db_out[1], 1);

    // Simultaneous press of buttons 0 and 3.
    button_in[0] = 1'b1;
    button_in[3] = 1'b1;
    repeat (40) tick();
    chk("simul_db", db_out, 4'b1011);

    // Release button 3 while holding others.
    button_in[3] = 1'b0;
    repeat (25) tick();
    chk("release_db", db_out, 4'b0011);

    // Random traffic: sparse edges, occasional bounce bursts, random backpressure.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0)
        button_in[$urandom_range(0, NUM_BTN-1)] ^= 1'b1;
      if ($urandom_range(0, 299) == 0) begin
        int b;
        b = $urandom_range(0, NUM_BTN-1);
        for (int k = 0; k < $urandom_range(2, 12); k++) begin
          button_in[b] ^= 1'b1;
          tick();
        end
      end
`ifdef BTN_SCAN_EVT_EN
      evt_ready = ($urandom_range(0, 3) != 0);
`endif
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/button_scan_ctrl.md
# button_scan_ctrl

Debounce scheduler for the button bank: time-multiplexes a single shared debounce counter across `NUM_BTN` asynchronous button inputs and visits them round-robin. It replaces one counter per button with one counter plus a scan state machine. It publishes the debounced level vector and, optionally, a press/release event stream with a valid/ready handshake. It sits between the board button pins and the input-decode logic.

## Interface
- `NUM_BTN`, 4: number of button inputs, 2..16.
- `CNT_W`, 11: shared counter width. A level is committed after `2^(CNT_W-1)` consecutive matching cycles.
- `IDX_W`, 2: index width, `>= clog2(NUM_BTN)`.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `button_in`  in  NUM_BTN  raw asynchronous button levels.
- `db_out`  out  NUM_BTN  debounced levels.
- `scan_idx`  out  IDX_W  button currently owned by the scanner.
- `busy`  out  1  high while in COUNT or COMMIT.
- `evt_valid`  out  1  event pending (BTN_SCAN_EVT_EN only).
- `evt_ready`  in  1  consumer accepts the event (BTN_SCAN_EVT_EN only).
- `evt_idx`  out  IDX_W  button index of the event (BTN_SCAN_EVT_EN only).
- `evt_level`  out  1  1 = press, 0 = release (BTN_SCAN_EVT_EN only).

## Operation
- **Input synchronizer:** each `button_in[i]` passes through a 2-flop synchronizer, giving `sync[i]`. Only `sync` is used downstream.
- **State machine:** states SCAN, COUNT, COMMIT. Shared registers are `cnt` (CNT_W bits), `cand` (1 bit) and `idx`.
- **SCAN:**
  - If `sync[idx] != db_out[idx]`: set `cand <= sync[idx]`, `cnt <= 0`, go to COUNT.
  - Otherwise advance `idx` and stay in SCAN.
  - Advancing `idx` wraps from `NUM_BTN-1` to 0.
- **COUNT:**
  - If `sync[idx] != cand` (bounce): abort, set `cnt <= 0`, advance `idx`, go to SCAN.
  - Otherwise `cnt <= cnt+1`.
  - Enter COMMIT on the cycle the increment sets `cnt[CNT_W-1]`. COUNT therefore lasts exactly `2^(CNT_W-1)` cycles.
  - Unsigned arithmetic, no wrap; `cnt` is cleared on every entry to COUNT.
- **COMMIT:**
  - `db_out[idx] <= cand`.
  - With events enabled, also load `evt_idx <= idx`, `evt_level <= cand`, `evt_valid <= 1`.
  - Then advance `idx` and go to SCAN.
  - With events enabled, if `evt_valid && !evt_ready` the FSM holds in COMMIT: `db_out` is not written and `idx` does not advance.
- **Single owner:** only the button at `idx` can change. Other buttons' `sync` changes wait until the scanner reaches them.
- **Reverted input:** a button that returns to its committed level before being scanned produces no event.
- **Outputs:**
  - `scan_idx = idx` (registered).
  - `busy = (state != SCAN)`.

## Timing
- **Reset values:** state SCAN, `idx` 0, `cnt` 0, `cand` 0, sync flops 0, `db_out` all 0, `evt_valid` 0, `evt_idx` 0, `evt_level` 0.
- **Reset mid-operation:** an in-progress count is discarded and no event is emitted.
- **Latency:** with an idle bank and `idx` already at the button, a clean edge on `button_in[i]` reaches `db_out[i]` in 2 (sync) + 1 (SCAN) + `2^(CNT_W-1)` (COUNT) + 1 (COMMIT) cycles.
- **Worst case without stall:** add up to `NUM_BTN-1` cycles of SCAN, plus `(NUM_BTN-1)·(2^(CNT_W-1)+1)` if every other button is also committing.
- **Event timing:** `db_out` and `evt_valid` rise in the same cycle.
- **Handshake:**
  - An event transfers on `evt_valid && evt_ready` at the rising edge.
  - `evt_valid`, `evt_idx` and `evt_level` are stable while `evt_valid && !evt_ready`.
  - `evt_valid` deasserts the cycle after transfer unless a new COMMIT loads in that same cycle. Transfer and load in the same edge are legal, so back-to-back events are possible.
- **Bounce on the last COUNT cycle:** the bounce wins and no commit occurs.

## Configuration
- **`BTN_SCAN_EVT_EN` defined:**
  - The event register and the `evt_valid`, `evt_ready`, `evt_idx`, `evt_level` ports exist.
  - COMMIT stalls on backpressure as described above.
- **`BTN_SCAN_EVT_EN` undefined:**
  - The event ports and register are absent.
  - COMMIT always completes in one cycle.
  - `db_out`, `scan_idx` and `busy` behave identically otherwise.

## Test plan
All scenarios use `NUM_BTN=4`, `CNT_W=4`, so COUNT lasts 8 cycles.
- **Reset:** assert `reset` asynchronously mid-COUNT on button 2 → `db_out=4'b0000`, `evt_valid=0`, `scan_idx=0` immediately, before the next clock edge.
- **Clean press:** with the bank idle and `idx=0`, raise `button_in[0]` → `db_out[0]=1` exactly 12 cycles later, and one event with `idx=0`, `level=1`.
- **Bounce:** toggle `button_in[1]` every 3 cycles for 40 cycles, then hold at 1 → no event during bouncing, then exactly one press event for `idx=1`; `db_out[1]=1`.
- **Simultaneous:** raise buttons 0 and 3 in the same cycle → commits and events in order idx 0 then idx 3, each after its own 8-cycle COUNT.
- **Backpressure:** hold `evt_ready=0`, press button 0 then button 1 → the first event is held stable; the FSM stalls in COMMIT for idx 1 with `db_out[1]=0`. Release `evt_ready` → idx 0 transfers, idx 1 loads in the same edge, then `db_out[1]=1`.
- **Wrap and release:** release button 3 while holding button 0 → release event `idx=3`, `level=0`; `scan_idx` wraps 3→0 with no spurious event for button 0.
